iflow_ctrl: RTL and testbench
=============================

Name: iflow_ctrl

Overview:
Control slice of the CPU instruction flow. It combines three parts:
- a two-phase clock generator (phi1/phi2);
- an opcode decoder FSM that handshakes with the fetcher and drives register write enables and bus selectors;
- one 1-to-8 registered fan-out lane that steers the routing bus into one of eight destinations.

Shared selector and write-enable encodings come from the common package.

Parameters:
REG_WIDTH, 8, data/operand width (from package)
SEL_WIDTH, 3, selector width
WE_WIDTH, 8, write-enable vector width

Ports:
clk  input  1  master clock (phi0)
reset_n  input  1  asynchronous active-low reset
phi1  output  1  phase 1 = clk
phi2  output  1  phase 2 = ~clk
instruction_in  input  8  byte from fetcher
instruction_ready  input  1  instruction_in valid this cycle
get_next  output  1  request next byte from fetcher
opp  output  3  decoded operation class
we  output  8  write enables: bit0 PC, 1 SP, 2 ADD, 3 X, 4 Y, 5 STAT, 6 DOUT, 7 spare
read_write  output  1  1 = memory write
source_selector_0, target_selector_0  output  3 each  lane-0 selectors
source_selector_1, target_selector_1  output  3 each  lane-1 selectors
imm_addr  output  8  latched operand (immediate or zero-page address)
route_in  input  8  fan lane data input
route_out0..route_out7  output  8 each  fan lane destinations

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Phases: phi1 = clk, phi2 = ~clk. Both are combinational and unaffected by reset.
- Decoder timing: all decoder outputs are registered on rising clk (phi1).
- Selector encoding (source): 0 PC, 1 ADD, 2 X, 3 Y, 4 IMM, 5 MEM, 6 ZERO, 7 FETCH.
- Selector encoding (target): 0 PC, 1 ADD, 2 X, 3 Y, 4 NULL, 5 MEM, 6 ALU, 7 FETCH.
- Idle and reset values:
  - we = 0, read_write = 0, opp = 0, imm_addr = 0, get_next = 0.
  - Both source selectors = 6, both target selectors = 4.
  - Lane-1 selectors hold these values permanently.
- FSM states: FETCH_OP, FETCH_OPND, EXECUTE. Reset state is FETCH_OP.
- FETCH_OP:
  - get_next = 1.
  - On instruction_ready, latch the opcode.
  - Implied opcodes go to EXECUTE; operand opcodes go to FETCH_OPND.
- FETCH_OPND:
  - get_next = 1.
  - On instruction_ready, latch imm_addr and go to EXECUTE.
- EXECUTE:
  - Exactly one cycle; get_next = 0.
  - Drives opp, we, read_write and lane-0 selectors, then returns to FETCH_OP.
- Opcode table (src -> tgt, we, opp):
  - AA TAX: 1 -> 2, we = 08, opp 1
  - 8A TXA: 2 -> 1, we = 04, opp 1
  - A8 TAY: 1 -> 3, we = 10, opp 1
  - 98 TYA: 3 -> 1, we = 04, opp 1
  - A9 LDA#: 4 -> 1, we = 04, opp 2
  - A2 LDX#: 4 -> 2, we = 08, opp 2
  - A0 LDY#: 4 -> 3, we = 10, opp 2
  - A5 LDA zp: 5 -> 1, we = 04, opp 3
  - 85 STA zp: 1 -> 5, we = 40, read_write = 1, opp 4
  - EA and any unlisted opcode: NOP, idle values in EXECUTE, opp 0
- instruction_ready low: the current state holds.
- Fan lane:
  - On rising phi2 (falling clk), route_out[target_selector_0] <= route_in. All other outputs hold.
  - Target 4 writes route_out4, which is defined as the discard slot.
  - Reset clears all route_out to 0.
  - An EXECUTE selector is therefore captured half a cycle after it is issued.
- Reset mid-instruction: asserting reset_n in any state returns immediately to FETCH_OP with idle outputs and discards the latched opcode and operand.

Decomposition:
- Package: REG_WIDTH, WE_* bit indices, SELECTOR_* source/target codes, opcode constants, opp codes, FSM state typedef.
- Natural sub-module: iflow_fan8 (registered 1-to-8 steering lane).
- Clock phase and decoder logic stay inline.

Test Plan:
- Reset: hold reset_n = 0 with clk toggling -> we = 00, src0 = 6, tgt0 = 4, get_next = 0, all route_out = 00. After release, get_next = 1 at the first rising clk.
- TAX: AA with instruction_ready -> next cycle EXECUTE with src0 = 1, tgt0 = 2, we = 08, opp = 1, get_next = 0. The following cycle returns to idle values with get_next = 1.
- LDA #$5C: A9 then 5C -> imm_addr = 5C, src0 = 4, tgt0 = 1, we = 04, opp = 2.
- STA $1F: 85 then 1F -> imm_addr = 1F, src0 = 1, tgt0 = 5, we = 40, read_write = 1, opp = 4.
- Fan: during LDY# EXECUTE (tgt0 = 3), route_in = 3C -> at the falling clk route_out3 = 3C, all other outputs unchanged.
- Edge cases:
  - Opcode FF -> NOP EXECUTE with we = 00.
  - Operand phase with instruction_ready held low for 3 cycles -> stays in FETCH_OPND.
  - Reset asserted in FETCH_OPND -> FETCH_OP with imm_addr = 00.

Source files
------------

// File: rtl/iflow_ctrl_pkg.sv
// Shared encodings for the instruction-flow control slice: selector codes,
// write-enable bit positions, opcodes, operation classes and decoder types.
package iflow_ctrl_pkg;

    localparam int REG_WIDTH = 8;
    localparam int SEL_WIDTH = 3;
    localparam int WE_WIDTH  = 8;
    localparam int OPP_WIDTH = 3;

    localparam int WE_PC    = 0;
    localparam int WE_SP    = 1;
    localparam int WE_ADD   = 2;
    localparam int WE_X     = 3;
    localparam int WE_Y     = 4;
    localparam int WE_STAT  = 5;
    localparam int WE_DOUT  = 6;
    localparam int WE_SPARE = 7;

    localparam logic [SEL_WIDTH-1:0] SRC_PC    = 3'd0;
    localparam logic [SEL_WIDTH-1:0] SRC_ADD   = 3'd1;
    localparam logic [SEL_WIDTH-1:0] SRC_X     = 3'd2;
    localparam logic [SEL_WIDTH-1:0] SRC_Y     = 3'd3;
    localparam logic [SEL_WIDTH-1:0] SRC_IMM   = 3'd4;
    localparam logic [SEL_WIDTH-1:0] SRC_MEM   = 3'd5;
    localparam logic [SEL_WIDTH-1:0] SRC_ZERO  = 3'd6;
    localparam logic [SEL_WIDTH-1:0] SRC_FETCH = 3'd7;

    localparam logic [SEL_WIDTH-1:0] TGT_PC    = 3'd0;
    localparam logic [SEL_WIDTH-1:0] TGT_ADD   = 3'd1;
    localparam logic [SEL_WIDTH-1:0] TGT_X     = 3'd2;
    localparam logic [SEL_WIDTH-1:0] TGT_Y     = 3'd3;
    localparam logic [SEL_WIDTH-1:0] TGT_NULL  = 3'd4;
    localparam logic [SEL_WIDTH-1:0] TGT_MEM   = 3'd5;
    localparam logic [SEL_WIDTH-1:0] TGT_ALU   = 3'd6;
    localparam logic [SEL_WIDTH-1:0] TGT_FETCH = 3'd7;

    localparam logic [REG_WIDTH-1:0] OP_TAX    = 8'hAA;
    localparam logic [REG_WIDTH-1:0] OP_TXA    = 8'h8A;
    localparam logic [REG_WIDTH-1:0] OP_TAY    = 8'hA8;
    localparam logic [REG_WIDTH-1:0] OP_TYA    = 8'h98;
    localparam logic [REG_WIDTH-1:0] OP_LDA_IM = 8'hA9;
    localparam logic [REG_WIDTH-1:0] OP_LDX_IM = 8'hA2;
    localparam logic [REG_WIDTH-1:0] OP_LDY_IM = 8'hA0;
    localparam logic [REG_WIDTH-1:0] OP_LDA_ZP = 8'hA5;
    localparam logic [REG_WIDTH-1:0] OP_STA_ZP = 8'h85;
    localparam logic [REG_WIDTH-1:0] OP_NOP    = 8'hEA;

    localparam logic [OPP_WIDTH-1:0] OPP_NOP   = 3'd0;
    localparam logic [OPP_WIDTH-1:0] OPP_XFER  = 3'd1;
    localparam logic [OPP_WIDTH-1:0] OPP_IMM   = 3'd2;
    localparam logic [OPP_WIDTH-1:0] OPP_LOAD  = 3'd3;
    localparam logic [OPP_WIDTH-1:0] OPP_STORE = 3'd4;

    typedef enum logic [1:0] {
        ST_FETCH_OP   = 2'd0,
        ST_FETCH_OPND = 2'd1,
        ST_EXECUTE    = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPP_WIDTH-1:0] opp;
        logic [WE_WIDTH-1:0]  we;
        logic                 read_write;
        logic [SEL_WIDTH-1:0] src;
        logic [SEL_WIDTH-1:0] tgt;
    } decode_t;

    function automatic logic [WE_WIDTH-1:0] we_bit(input int idx);
        logic [WE_WIDTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic decode_t idle_decode();
        decode_t d;
        d.opp        = OPP_NOP;
        d.we         = '0;
        d.read_write = 1'b0;
        d.src        = SRC_ZERO;
        d.tgt        = TGT_NULL;
        return d;
    endfunction

    function automatic logic has_operand(input logic [REG_WIDTH-1:0] op);
        logic r;
        case (op)
            OP_LDA_IM, OP_LDX_IM, OP_LDY_IM, OP_LDA_ZP, OP_STA_ZP: r = 1'b1;
            default:                                               r = 1'b0;
        endcase
        return r;
    endfunction

    // Unknown opcodes deliberately fall back to the idle (NOP) decode.
    function automatic decode_t decode_op(input logic [REG_WIDTH-1:0] op);
        decode_t d;
        d = idle_decode();
        case (op)
            OP_TAX:    begin d.opp = OPP_XFER;  d.src = SRC_ADD; d.tgt = TGT_X;   d.we = we_bit(WE_X);   end
            OP_TXA:    begin d.opp = OPP_XFER;  d.src = SRC_X;   d.tgt = TGT_ADD; d.we = we_bit(WE_ADD); end
            OP_TAY:    begin d.opp = OPP_XFER;  d.src = SRC_ADD; d.tgt = TGT_Y;   d.we = we_bit(WE_Y);   end
            OP_TYA:    begin d.opp = OPP_XFER;  d.src = SRC_Y;   d.tgt = TGT_ADD; d.we = we_bit(WE_ADD); end
            OP_LDA_IM: begin d.opp = OPP_IMM;   d.src = SRC_IMM; d.tgt = TGT_ADD; d.we = we_bit(WE_ADD); end
            OP_LDX_IM: begin d.opp = OPP_IMM;   d.src = SRC_IMM; d.tgt = TGT_X;   d.we = we_bit(WE_X);   end
            OP_LDY_IM: begin d.opp = OPP_IMM;   d.src = SRC_IMM; d.tgt = TGT_Y;   d.we = we_bit(WE_Y);   end
            OP_LDA_ZP: begin d.opp = OPP_LOAD;  d.src = SRC_MEM; d.tgt = TGT_ADD; d.we = we_bit(WE_ADD); end
            OP_STA_ZP: begin
                d.opp        = OPP_STORE;
                d.src        = SRC_ADD;
                d.tgt        = TGT_MEM;
                d.we         = we_bit(WE_DOUT);
                d.read_write = 1'b1;
            end
            OP_NOP:    d = idle_decode();
            default:   d = idle_decode();
        endcase
        return d;
    endfunction

endpackage

// File: rtl/iflow_ctrl_if.sv
// Fetch handshake and decoded-control bus between the decoder and the datapath.
interface iflow_ctrl_if;
    import iflow_ctrl_pkg::*;

    logic [REG_WIDTH-1:0] instruction_in;
    logic                 instruction_ready;
    logic                 get_next;
    logic [OPP_WIDTH-1:0] opp;
    logic [WE_WIDTH-1:0]  we;
    logic                 read_write;
    logic [SEL_WIDTH-1:0] source_selector_0;
    logic [SEL_WIDTH-1:0] target_selector_0;
    logic [SEL_WIDTH-1:0] source_selector_1;
    logic [SEL_WIDTH-1:0] target_selector_1;
    logic [REG_WIDTH-1:0] imm_addr;

    modport master (
        input  instruction_in, instruction_ready,
        output get_next, opp, we, read_write,
               source_selector_0, target_selector_0,
               source_selector_1, target_selector_1, imm_addr
    );

    modport slave (
        output instruction_in, instruction_ready,
        input  get_next, opp, we, read_write,
               source_selector_0, target_selector_0,
               source_selector_1, target_selector_1, imm_addr
    );
endinterface

// File: rtl/iflow_ctrl_fan8.sv
// Registered 1-to-8 steering lane, updated on the falling clock edge (phi2)
// so that a selector issued at the rising edge is captured half a cycle later.
module iflow_fan8
    import iflow_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SEL_WIDTH-1:0]          sel,
    input  logic [REG_WIDTH-1:0]          data,
    output logic [7:0][REG_WIDTH-1:0]     route_q
);

    // Destination register bank: only the selected slot loads each phi2 edge.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            route_q <= '0;
        end else begin
            route_q[sel] <= data;
        end
    end

endmodule

// File: rtl/iflow_ctrl.sv
// Instruction-flow control slice: phase generator, opcode decoder FSM with
// fetch handshake, and the lane-0 routing fan-out.
module iflow_ctrl
    import iflow_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 phi1,
    output logic                 phi2,
    iflow_ctrl_if.master         bus,
    input  logic [REG_WIDTH-1:0] route_in,
    output logic [REG_WIDTH-1:0] route_out0,
    output logic [REG_WIDTH-1:0] route_out1,
    output logic [REG_WIDTH-1:0] route_out2,
    output logic [REG_WIDTH-1:0] route_out3,
    output logic [REG_WIDTH-1:0] route_out4,
    output logic [REG_WIDTH-1:0] route_out5,
    output logic [REG_WIDTH-1:0] route_out6,
    output logic [REG_WIDTH-1:0] route_out7
);

    state_e               state_r;
    state_e               state_s;
    logic [REG_WIDTH-1:0] opcode_r;
    logic [REG_WIDTH-1:0] opcode_s;
    logic [REG_WIDTH-1:0] imm_r;
    logic [REG_WIDTH-1:0] imm_s;
    decode_t              dec_r;
    decode_t              dec_s;
    logic                 get_next_r;
    logic                 get_next_s;
    logic [7:0][REG_WIDTH-1:0] route_q;

    assign phi1 = clk;
    assign phi2 = ~clk;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_FETCH_OP;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus the output values to present in that next state.
    always_comb begin
        state_s  = state_r;
        opcode_s = opcode_r;
        imm_s    = 8'h00;
        dec_s    = idle_decode();
        case (state_r)
            ST_FETCH_OP: begin
                if (bus.instruction_ready) begin
                    opcode_s = bus.instruction_in;
                    if (has_operand(bus.instruction_in)) begin
                        state_s = ST_FETCH_OPND;
                    end else begin
                        state_s = ST_EXECUTE;
                        dec_s   = decode_op(bus.instruction_in);
                    end
                end else begin
                    state_s = ST_FETCH_OP;
                end
            end
            ST_FETCH_OPND: begin
                if (bus.instruction_ready) begin
                    state_s = ST_EXECUTE;
                    imm_s   = bus.instruction_in;
                    dec_s   = decode_op(opcode_r);
                end else begin
                    state_s = ST_FETCH_OPND;
                end
            end
            ST_EXECUTE: state_s = ST_FETCH_OP;
            default:    state_s = ST_FETCH_OP;
        endcase
        get_next_s = (state_s != ST_EXECUTE);
    end

    // Decoder output and latch registers; reset discards any partial instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_r   <= 8'h00;
            imm_r      <= 8'h00;
            dec_r      <= idle_decode();
            get_next_r <= 1'b0;
        end else begin
            opcode_r   <= opcode_s;
            imm_r      <= imm_s;
            dec_r      <= dec_s;
            get_next_r <= get_next_s;
        end
    end

    assign bus.get_next          = get_next_r;
    assign bus.opp               = dec_r.opp;
    assign bus.we                = dec_r.we;
    assign bus.read_write        = dec_r.read_write;
    assign bus.source_selector_0 = dec_r.src;
    assign bus.target_selector_0 = dec_r.tgt;
    assign bus.source_selector_1 = SRC_ZERO;
    assign bus.target_selector_1 = TGT_NULL;
    assign bus.imm_addr          = imm_r;

    iflow_fan8 u_fan (
        .clk     (clk),
        .reset_n (reset_n),
        .sel     (dec_r.tgt),
        .data    (route_in),
        .route_q (route_q)
    );

    assign route_out0 = route_q[0];
    assign route_out1 = route_q[1];
    assign route_out2 = route_q[2];
    assign route_out3 = route_q[3];
    assign route_out4 = route_q[4];
    assign route_out5 = route_q[5];
    assign route_out6 = route_q[6];
    assign route_out7 = route_q[7];

endmodule

// File: tb/tb_iflow_ctrl.sv
// Directed self-checking bench for iflow_ctrl with an EXECUTE-cycle scoreboard.
module tb_iflow_ctrl;

    logic       clk;
    logic       reset_n;
    logic       phi1;
    logic       phi2;
    logic [7:0] route_in;
    logic [7:0] route_out [8];
    logic [7:0] exp_route [8];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [2:0] src;
        logic [2:0] tgt;
        logic [7:0] we;
        logic [2:0] opp;
        logic       rw;
        logic [7:0] imm;
    } exp_t;

    exp_t sb[$];

    iflow_ctrl_if bus();

    iflow_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .phi1       (phi1),
        .phi2       (phi2),
        .bus        (bus.master),
        .route_in   (route_in),
        .route_out0 (route_out[0]),
        .route_out1 (route_out[1]),
        .route_out2 (route_out[2]),
        .route_out3 (route_out[3]),
        .route_out4 (route_out[4]),
        .route_out5 (route_out[5]),
        .route_out6 (route_out[6]),
        .route_out7 (route_out[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] src, input logic [2:0] tgt,
                            input logic [7:0] we, input logic [2:0] opp, input logic rw,
                            input logic [7:0] imm);
        exp_t e;
        e.tag = tag; e.src = src; e.tgt = tgt; e.we = we;
        e.opp = opp; e.rw = rw;   e.imm = imm;
        sb.push_back(e);
    endtask

    // Present one byte for one rising edge; returns at posedge+1.
    task automatic feed(input logic [7:0] b);
        bus.instruction_in    = b;
        bus.instruction_ready = 1'b1;
        @(posedge clk); #1;
        bus.instruction_ready = 1'b0;
        bus.instruction_in    = 8'h00;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_exec();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_src0"}, {5'd0, bus.source_selector_0}, {5'd0, e.src});
            chk({e.tag, "_tgt0"}, {5'd0, bus.target_selector_0}, {5'd0, e.tgt});
            chk({e.tag, "_we"},   bus.we, e.we);
            chk({e.tag, "_opp"},  {5'd0, bus.opp}, {5'd0, e.opp});
            chk({e.tag, "_rw"},   {7'd0, bus.read_write}, {7'd0, e.rw});
            chk({e.tag, "_imm"},  bus.imm_addr, e.imm);
            chk({e.tag, "_getnext"}, {7'd0, bus.get_next}, 8'h00);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] gn);
        chk({tag, "_getnext"}, {7'd0, bus.get_next}, gn);
        chk({tag, "_we"},   bus.we, 8'h00);
        chk({tag, "_src0"}, {5'd0, bus.source_selector_0}, 8'h06);
        chk({tag, "_tgt0"}, {5'd0, bus.target_selector_0}, 8'h04);
        chk({tag, "_opp"},  {5'd0, bus.opp}, 8'h00);
        chk({tag, "_rw"},   {7'd0, bus.read_write}, 8'h00);
        chk({tag, "_imm"},  bus.imm_addr, 8'h00);
        chk({tag, "_src1"}, {5'd0, bus.source_selector_1}, 8'h06);
        chk({tag, "_tgt1"}, {5'd0, bus.target_selector_1}, 8'h04);
    endtask

    task automatic check_routes(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_route%0d", tag, i), route_out[i], exp_route[i]);
        end
    endtask

    task automatic run_implied(input string tag, input logic [7:0] op, input logic [2:0] src,
                               input logic [2:0] tgt, input logic [7:0] we, input logic [2:0] opp);
        push_exp(tag, src, tgt, we, opp, 1'b0, 8'h00);
        feed(op);
        check_exec();
        step();
        check_idle({tag, "_after"}, 8'h01);
    endtask

    task automatic run_operand(input string tag, input logic [7:0] op, input logic [7:0] opnd,
                               input logic [2:0] src, input logic [2:0] tgt, input logic [7:0] we,
                               input logic [2:0] opp, input logic rw);
        feed(op);
        check_idle({tag, "_opnd"}, 8'h01);
        push_exp(tag, src, tgt, we, opp, rw, opnd);
        feed(opnd);
        check_exec();
        step();
        check_idle({tag, "_after"}, 8'h01);
    endtask

    initial begin
        reset_n               = 1'b0;
        route_in              = 8'h00;
        bus.instruction_in    = 8'h00;
        bus.instruction_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_route[i] = 8'h00;

        // Reset held with clock running.
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 8'h00);
        check_routes("reset");
        reset_n = 1'b1;
        #1;
        chk("release_getnext_low", {7'd0, bus.get_next}, 8'h00);
        @(posedge clk); #1;
        chk("first_edge_getnext", {7'd0, bus.get_next}, 8'h01);
        chk("phi1_high", {7'd0, phi1}, 8'h01);
        chk("phi2_low",  {7'd0, phi2}, 8'h00);
        @(negedge clk); #1;
        chk("phi1_low",  {7'd0, phi1}, 8'h00);
        chk("phi2_high", {7'd0, phi2}, 8'h01);
        step();

        run_implied("tax", 8'hAA, 3'd1, 3'd2, 8'h08, 3'd1);
        run_operand("lda_imm", 8'hA9, 8'h5C, 3'd4, 3'd1, 8'h04, 3'd2, 1'b0);

        // STA with the fan lane carrying A5 during EXECUTE.
        feed(8'h85);
        push_exp("sta_zp", 3'd1, 3'd5, 8'h40, 3'd4, 1'b1, 8'h1F);
        feed(8'h1F);
        route_in = 8'hA5;
        check_exec();
        @(negedge clk); #1;
        exp_route[5] = 8'hA5;
        check_routes("sta_fan");
        route_in = 8'h00;
        step();
        check_idle("sta_after", 8'h01);

        // LDY# with fan lane: only route_out3 changes.
        feed(8'hA0);
        push_exp("ldy_imm", 3'd4, 3'd3, 8'h10, 3'd2, 1'b0, 8'h77);
        feed(8'h77);
        route_in = 8'h3C;
        check_exec();
        @(negedge clk); #1;
        exp_route[3] = 8'h3C;
        check_routes("ldy_fan");
        route_in = 8'h00;
        step();
        check_idle("ldy_after", 8'h01);
        @(negedge clk); #1;
        check_routes("idle_discard");
        step();

        run_implied("txa", 8'h8A, 3'd2, 3'd1, 8'h04, 3'd1);
        run_implied("tay", 8'hA8, 3'd1, 3'd3, 8'h10, 3'd1);
        run_implied("tya", 8'h98, 3'd3, 3'd1, 8'h04, 3'd1);
        run_operand("ldx_imm", 8'hA2, 8'h99, 3'd4, 3'd2, 8'h08, 3'd2, 1'b0);
        run_operand("lda_zp", 8'hA5, 8'h33, 3'd5, 3'd1, 8'h04, 3'd3, 1'b0);
        run_implied("nop_ea", 8'hEA, 3'd6, 3'd4, 8'h00, 3'd0);
        run_implied("nop_ff", 8'hFF, 3'd6, 3'd4, 8'h00, 3'd0);

        // Idle in FETCH_OP with ready low.
        repeat (2) step();
        check_idle("fetchop_hold", 8'h01);

        // Operand phase stalls for 3 cycles; 42 must still be taken as operand.
        feed(8'hA9);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("opnd_stall%0d", i), 8'h01);
        end
        push_exp("lda_stalled", 3'd4, 3'd1, 8'h04, 3'd2, 1'b0, 8'h42);
        feed(8'h42);
        check_exec();
        step();

        // Reset in FETCH_OPND discards opcode and clears the fan lane.
        feed(8'hA2);
        reset_n = 1'b0;
        #1;
        check_idle("midreset", 8'h00);
        for (int i = 0; i < 8; i++) exp_route[i] = 8'h00;
        check_routes("midreset");
        step();
        reset_n = 1'b1;
        step();
        chk("postreset_getnext", {7'd0, bus.get_next}, 8'h01);
        run_implied("postreset_tax", 8'hAA, 3'd1, 3'd2, 8'h08, 3'd1);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
